// File: rtl/rhythm_judge.sv
// Multi-lane rhythm-game judge: shifts per-lane note maps on tick, grades presses, keeps saturating score/combo.
// Optional grade counters are built when JUDGE_STATS_EN is defined; otherwise the counter ports are tied to 0.
module rhythm_judge #(
   parameter int LANES       = 4,
   parameter int DEPTH       = 192,
   parameter int VIEW        = 10,
   parameter int SCORE_W     = 8,
   parameter int COMBO_W     = 8,
   parameter int PERFECT_PTS = 2,
   parameter int GOOD_PTS    = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tick,
   input  logic                     start,
   input  logic [LANES*DEPTH-1:0]   map_in,
   input  logic [LANES-1:0]         buttons,
   output logic [LANES*VIEW-1:0]    lane_view,
   output logic [SCORE_W-1:0]       score,
   output logic [COMBO_W-1:0]       combo,
   output logic [COMBO_W-1:0]       max_combo,
   output logic [2*LANES-1:0]       accuracy,
   output logic                     busy,
   output logic                     done,
   output logic [15:0]              perfect_cnt,
   output logic [15:0]              good_cnt,
   output logic [15:0]              miss_cnt
);

   typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DONE = 2'd2} state_t;

   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
   localparam logic [COMBO_W-1:0] COMBO_MAX = '1;

   state_t               state;
   logic [DEPTH-1:0]     map_q [LANES];
   logic [DEPTH-1:0]     map_d [LANES];
   logic [DEPTH-1:0]     kept  [LANES];
   logic [LANES-1:0]     sync1, sync2, sync_prev, press;
   logic [LANES-1:0]     hit_perf, hit_good, stray, miss;
   logic                 active, load, all_clear, any_miss;
   logic [31:0]          hit_n, pts_n, score_sum, combo_sum;
   logic [SCORE_W-1:0]   score_d;
   logic [COMBO_W-1:0]   combo_d, max_d;
   logic [2*LANES-1:0]   acc_d;

   // Buttons are asynchronous and active-low; idle level is 1, so the chain resets to 1.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1     <= '1;
         sync2     <= '1;
         sync_prev <= '1;
      end else begin
         sync1     <= buttons;
         sync2     <= sync1;
         sync_prev <= sync2;
      end
   end

   assign press  = sync_prev & ~sync2;
   assign active = (state == PLAY) && !start;
   assign load   = start && (state != PLAY);

   for (genvar g = 0; g < LANES; g++) begin : g_view
      assign lane_view[g*VIEW +: VIEW] = map_q[g][VIEW:1];
   end

   // Judge against pre-shift contents, drop the consumed note, then shift if ticking.
   always_comb begin
      hit_perf  = '0;
      hit_good  = '0;
      stray     = '0;
      miss      = '0;
      acc_d     = accuracy;
      hit_n     = 32'd0;
      pts_n     = 32'd0;
      all_clear = 1'b1;
      for (int l = 0; l < LANES; l++) begin
         kept[l] = map_q[l];
         if (active && press[l]) begin
            if (map_q[l][1]) begin
               hit_perf[l] = 1'b1;
               kept[l][1]  = 1'b0;
            end else if (map_q[l][0]) begin
               hit_good[l] = 1'b1;
               kept[l][0]  = 1'b0;
            end else if (map_q[l][2]) begin
               hit_good[l] = 1'b1;
               kept[l][2]  = 1'b0;
            end else begin
               stray[l] = 1'b1;
            end
         end
         miss[l]  = active && tick && kept[l][0];
         map_d[l] = (active && tick) ? (kept[l] >> 1) : kept[l];
         if (miss[l])
            acc_d[2*l +: 2] = 2'b11;
         else if (hit_perf[l])
            acc_d[2*l +: 2] = 2'b01;
         else if (hit_good[l])
            acc_d[2*l +: 2] = 2'b10;
         else if (stray[l])
            acc_d[2*l +: 2] = 2'b00;
         if (hit_perf[l]) begin
            hit_n = hit_n + 32'd1;
            pts_n = pts_n + 32'(PERFECT_PTS);
         end else if (hit_good[l]) begin
            hit_n = hit_n + 32'd1;
            pts_n = pts_n + 32'(GOOD_PTS);
         end
         if (map_q[l] != '0)
            all_clear = 1'b0;
      end
      any_miss  = |miss;
      score_sum = 32'(score) + pts_n;
      score_d   = (score_sum > 32'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
      combo_sum = 32'(combo) + hit_n;
      if (any_miss)
         combo_d = '0;
      else if (combo_sum > 32'(COMBO_MAX))
         combo_d = COMBO_MAX;
      else
         combo_d = combo_sum[COMBO_W-1:0];
      max_d = (combo_d > max_combo) ? combo_d : max_combo;
   end

   // Game FSM plus the per-cycle scoring datapath; abort leaves maps and score untouched.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         score     <= '0;
         combo     <= '0;
         max_combo <= '0;
         accuracy  <= '0;
         for (int l = 0; l < LANES; l++)
            map_q[l] <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state     <= PLAY;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  score     <= '0;
                  combo     <= '0;
                  max_combo <= '0;
                  accuracy  <= '0;
                  for (int l = 0; l < LANES; l++)
                     map_q[l] <= map_in[l*DEPTH +: DEPTH];
               end
            end
            PLAY: begin
               if (start) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  score     <= score_d;
                  combo     <= combo_d;
                  max_combo <= max_d;
                  accuracy  <= acc_d;
                  for (int l = 0; l < LANES; l++)
                     map_q[l] <= map_d[l];
                  if (all_clear) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

`ifdef JUDGE_STATS_EN
   logic [31:0] perf_n, good_n, miss_n;

   function automatic logic [15:0] sat16(input logic [15:0] cur, input logic [31:0] inc);
      logic [31:0] sum;
      sum = 32'(cur) + inc;
      return (sum > 32'h0000_FFFF) ? 16'hFFFF : sum[15:0];
   endfunction

   always_comb begin
      perf_n = 32'd0;
      good_n = 32'd0;
      miss_n = 32'd0;
      for (int l = 0; l < LANES; l++) begin
         perf_n = perf_n + 32'(hit_perf[l]);
         good_n = good_n + 32'(hit_good[l]);
         miss_n = miss_n + 32'(miss[l]);
      end
   end

   // Grade counters clear with a fresh load, not on abort.
   always_ff @(posedge clk) begin
      if (!rst || load) begin
         perfect_cnt <= '0;
         good_cnt    <= '0;
         miss_cnt    <= '0;
      end else if (active) begin
         perfect_cnt <= sat16(perfect_cnt, perf_n);
         good_cnt    <= sat16(good_cnt, good_n);
         miss_cnt    <= sat16(miss_cnt, miss_n);
      end
   end
`else
   assign perfect_cnt = 16'd0;
   assign good_cnt    = 16'd0;
   assign miss_cnt    = 16'd0;
`endif

endmodule

// File: tb/tb_rhythm_judge.sv
// Directed scoreboard bench for rhythm_judge (LANES=2, DEPTH=16, VIEW=4, SCORE_W=4).
// Expected counter values follow JUDGE_STATS_EN when it is defined for the build.
module tb_rhythm_judge;

   localparam int LANES = 2, DEPTH = 16, VIEW = 4, SCORE_W = 4, COMBO_W = 8;
   localparam int OP_START = 0, OP_TICK = 1, OP_PRESS = 2, OP_STEP = 3;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    tick;
   logic                    start;
   logic [LANES*DEPTH-1:0]  map_in;
   logic [LANES-1:0]        buttons;
   logic [LANES*VIEW-1:0]   lane_view;
   logic [SCORE_W-1:0]      score;
   logic [COMBO_W-1:0]      combo, max_combo;
   logic [2*LANES-1:0]      accuracy;
   logic                    busy, done;
   logic [15:0]             perfect_cnt, good_cnt, miss_cnt;

   typedef struct {
      string       tag;
      logic [31:0] sc, cb, mx, acc, bz, dn, view, pc, gc, mc;
   } exp_t;

   exp_t expQ[$];
   int   checkCnt = 0;
   int   passCnt  = 0;

   rhythm_judge #(
      .LANES(LANES), .DEPTH(DEPTH), .VIEW(VIEW), .SCORE_W(SCORE_W), .COMBO_W(COMBO_W),
      .PERFECT_PTS(2), .GOOD_PTS(1)
   ) dut (
      .clk(clk), .rst(rst), .tick(tick), .start(start), .map_in(map_in), .buttons(buttons),
      .lane_view(lane_view), .score(score), .combo(combo), .max_combo(max_combo),
      .accuracy(accuracy), .busy(busy), .done(done),
      .perfect_cnt(perfect_cnt), .good_cnt(good_cnt), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] st(input int v);
`ifdef JUDGE_STATS_EN
      return 32'(v);
`else
      return 32'(v * 0);
`endif
   endfunction

   task automatic applyStimulus(input int op, input logic [15:0] m0, input logic [15:0] m1,
                                input logic [1:0] mask, input logic withTick);
      case (op)
         OP_START: begin
            map_in = {m1, m0};
            start  = 1'b1;
            tick   = withTick;
            @(negedge clk);
            start  = 1'b0;
            tick   = 1'b0;
         end
         OP_TICK: begin
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
         end
         OP_PRESS: begin
            buttons = ~mask;
            @(negedge clk);
            @(negedge clk);
            tick    = withTick;
            buttons = '1;
            @(negedge clk);
            tick    = 1'b0;
            @(negedge clk);
            @(negedge clk);
         end
         default: @(negedge clk);
      endcase
   endtask

   task automatic pushExpect(input string tag, input int sc, input int cb, input int mx,
                             input int acc, input int bz, input int dn, input int view,
                             input logic [31:0] pc, input logic [31:0] gc, input logic [31:0] mc);
      exp_t e;
      e.tag = tag;  e.sc = 32'(sc); e.cb = 32'(cb); e.mx = 32'(mx); e.acc = 32'(acc);
      e.bz = 32'(bz); e.dn = 32'(dn); e.view = 32'(view); e.pc = pc; e.gc = gc; e.mc = mc;
      expQ.push_back(e);
   endtask

   task automatic compareField(input string tag, input string field,
                               input logic [31:0] got, input logic [31:0] want);
      checkCnt++;
      assert (got === want) passCnt++;
      else $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, field, got, want);
   endtask

   task automatic checkOutput();
      exp_t e;
      if (expQ.size() == 0) begin
         checkCnt++;
         $error("[TB] FAIL scoreboard observed=empty expected=entry");
         return;
      end
      e = expQ.pop_front();
      compareField(e.tag, "score",     32'(score),       e.sc);
      compareField(e.tag, "combo",     32'(combo),       e.cb);
      compareField(e.tag, "max_combo", 32'(max_combo),   e.mx);
      compareField(e.tag, "accuracy",  32'(accuracy),    e.acc);
      compareField(e.tag, "busy",      32'(busy),        e.bz);
      compareField(e.tag, "done",      32'(done),        e.dn);
      compareField(e.tag, "lane_view", 32'(lane_view),   e.view);
      compareField(e.tag, "perf_cnt",  32'(perfect_cnt), e.pc);
      compareField(e.tag, "good_cnt",  32'(good_cnt),    e.gc);
      compareField(e.tag, "miss_cnt",  32'(miss_cnt),    e.mc);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b0; tick = 1'b0; start = 1'b0; map_in = '0; buttons = '1;
      repeat (3) @(negedge clk);
      pushExpect("reset", 0, 0, 0, 0, 0, 0, 8'h00, st(0), st(0), st(0));
      checkOutput();
      rst = 1'b1;
      @(negedge clk);

      applyStimulus(OP_START, 16'h0002, 16'h8000, 2'b00, 1'b0);
      pushExpect("load1", 0, 0, 0, 0, 1, 0, 8'h01, st(0), st(0), st(0));
      checkOutput();
      applyStimulus(OP_PRESS, 16'h0, 16'h0, 2'b01, 1'b0);
      pushExpect("perfect", 2, 1, 1, 4'b0001, 1, 0, 8'h00, st(1), st(0), st(0));
      checkOutput();
      applyStimulus(OP_TICK, 16'h0, 16'h0, 2'b00, 1'b0);
      pushExpect("noMissAfterHit", 2, 1, 1, 4'b0001, 1, 0, 8'h00, st(1), st(0), st(0));
      checkOutput();
      applyStimulus(OP_START, 16'hFFFF, 16'hFFFF, 2'b00, 1'b0);
      pushExpect("abort", 2, 1, 1, 4'b0001, 0, 0, 8'h00, st(1), st(0), st(0));
      checkOutput();

      applyStimulus(OP_START, 16'h0001, 16'h8000, 2'b00, 1'b0);
      pushExpect("load2", 0, 0, 0, 0, 1, 0, 8'h00, st(0), st(0), st(0));
      checkOutput();
      applyStimulus(OP_TICK, 16'h0, 16'h0, 2'b00, 1'b0);
      pushExpect("miss", 0, 0, 0, 4'b0011, 1, 0, 8'h00, st(0), st(0), st(1));
      checkOutput();
      applyStimulus(OP_START, 16'h0, 16'h0, 2'b00, 1'b0);

      applyStimulus(OP_START, 16'h8002, 16'h8002, 2'b00, 1'b0);
      pushExpect("load3", 0, 0, 0, 0, 1, 0, 8'h11, st(0), st(0), st(0));
      checkOutput();
      applyStimulus(OP_PRESS, 16'h0, 16'h0, 2'b11, 1'b1);
      pushExpect("dualPressTick", 4, 2, 2, 4'b0101, 1, 0, 8'h00, st(2), st(0), st(0));
      checkOutput();
      applyStimulus(OP_TICK, 16'h0, 16'h0, 2'b00, 1'b0);
      pushExpect("dualNoMiss", 4, 2, 2, 4'b0101, 1, 0, 8'h00, st(2), st(0), st(0));
      checkOutput();
      applyStimulus(OP_START, 16'h0, 16'h0, 2'b00, 1'b0);

      applyStimulus(OP_START, 16'h03FE, 16'h8000, 2'b00, 1'b0);
      for (int i = 0; i < 8; i++)
         applyStimulus(OP_PRESS, 16'h0, 16'h0, 2'b01, 1'b1);
      pushExpect("scoreSat", 15, 8, 8, 4'b0001, 1, 0, 8'h01, st(8), st(0), st(0));
      checkOutput();
      applyStimulus(OP_TICK, 16'h0, 16'h0, 2'b00, 1'b0);
      applyStimulus(OP_TICK, 16'h0, 16'h0, 2'b00, 1'b0);
      pushExpect("satMiss", 15, 0, 8, 4'b0011, 1, 0, 8'h00, st(8), st(0), st(1));
      checkOutput();
      applyStimulus(OP_PRESS, 16'h0, 16'h0, 2'b01, 1'b0);
      pushExpect("stray", 15, 0, 8, 4'b0000, 1, 0, 8'h00, st(8), st(0), st(1));
      checkOutput();
      applyStimulus(OP_START, 16'h0, 16'h0, 2'b00, 1'b0);

      applyStimulus(OP_START, 16'h8001, 16'h0004, 2'b00, 1'b0);
      applyStimulus(OP_PRESS, 16'h0, 16'h0, 2'b11, 1'b0);
      pushExpect("lateEarlyGood", 2, 2, 2, 4'b1010, 1, 0, 8'h00, st(0), st(2), st(0));
      checkOutput();
      applyStimulus(OP_START, 16'h0, 16'h0, 2'b00, 1'b0);

      applyStimulus(OP_START, 16'h0004, 16'h0000, 2'b00, 1'b0);
      repeat (3) applyStimulus(OP_TICK, 16'h0, 16'h0, 2'b00, 1'b0);
      pushExpect("lastNoteGone", 0, 0, 0, 4'b0011, 1, 0, 8'h00, st(0), st(0), st(1));
      checkOutput();
      applyStimulus(OP_STEP, 16'h0, 16'h0, 2'b00, 1'b0);
      pushExpect("done", 0, 0, 0, 4'b0011, 0, 1, 8'h00, st(0), st(0), st(1));
      checkOutput();

      applyStimulus(OP_START, 16'h0002, 16'h8000, 2'b00, 1'b0);
      applyStimulus(OP_PRESS, 16'h0, 16'h0, 2'b01, 1'b0);
      pushExpect("restartHit", 2, 1, 1, 4'b0001, 1, 0, 8'h00, st(1), st(0), st(0));
      checkOutput();
      rst = 1'b0;
      @(negedge clk);
      pushExpect("midReset", 0, 0, 0, 0, 0, 0, 8'h00, st(0), st(0), st(0));
      checkOutput();
      rst = 1'b1;
      @(negedge clk);

      applyStimulus(OP_START, 16'h0004, 16'h0000, 2'b00, 1'b1);
      pushExpect("startWinsTick", 0, 0, 0, 0, 1, 0, 8'h02, st(0), st(0), st(0));
      checkOutput();

      $display("[TB] %0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule

// File: doc/rhythm_judge.md
# rhythm_judge

Multi-lane, parametrised rhythm-game judging engine. It holds one note map per lane in shift registers and advances them on an external step strobe. It grades debounced button presses as perfect, good or miss, and maintains saturating score, combo and max-combo counters. It sits between the step-clock divider and the hex/VGA display logic, and replaces the single-lane judge in the datapath.

## Interface
- LANES, 4: number of independent note lanes/buttons.
- DEPTH, 192: map length per lane in steps; must be ≥ VIEW+3.
- VIEW, 10: upcoming steps per lane exported for display.
- SCORE_W, 8: score width.
- COMBO_W, 8: combo and max-combo width.
- PERFECT_PTS, 2: points for a perfect hit.
- GOOD_PTS, 1: points for a good hit.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- tick  in  1  one-cycle step strobe; shifts all lanes.
- start  in  1  one-cycle pulse; load/start, or abort while playing.
- map_in  in  LANES*DEPTH  initial maps; lane l occupies [l*DEPTH +: DEPTH]; bit 0 is the next note to arrive.
- buttons  in  LANES  raw buttons, active-low, asynchronous.
- lane_view  out  LANES*VIEW  lane l = map bits [VIEW:1].
- score  out  SCORE_W  accumulated points.
- combo  out  COMBO_W  current consecutive hits.
- max_combo  out  COMBO_W  highest combo this run.
- accuracy  out  2*LANES  per-lane last grade: 00 none, 01 perfect, 10 good, 11 miss.
- busy  out  1  high in PLAY.
- done  out  1  high in DONE.
- perfect_cnt, good_cnt, miss_cnt  out  16 each  grade counters (see Configuration).

## Operation
- States: IDLE, PLAY, DONE. Reset enters IDLE.
- IDLE or DONE + start: load map_in, clear score/combo/max_combo/accuracy/counters, go to PLAY.
- PLAY + start: abort to IDLE. Map and counters are held.
- PLAY with every lane map all-zero: go to DONE.
- Buttons pass through a 2-flop synchroniser, which resets to 1. Press = previous synced value 1 and current synced value 0.
- Judge window per lane:
  - bit 1 = perfect.
  - bit 0 = late good.
  - bit 2 = early good.
  - Priority is perfect > late > early. The consumed bit is cleared.
- A press with no note in the window sets that lane's accuracy to 00. Score and combo are unchanged.
- Miss: in PLAY, a tick while lane bit 0 = 1 and that bit is not consumed in the same cycle. That lane's accuracy becomes 11.
- Presses and misses are judged only in PLAY.
- Per-cycle update:
  - hits = count of hit lanes; pts = sum of their points.
  - score <= min(score+pts, 2^SCORE_W−1).
  - combo <= any miss ? 0 : min(combo+hits, 2^COMBO_W−1).
  - max_combo <= max(max_combo, new combo).
- Simultaneous press and tick: judge against pre-shift contents, clear the consumed bit, then shift right by one with zero fill.
- Accuracy per lane holds until that lane's next press or miss.

## Timing
- Reset values: all outputs 0, lane maps 0, state IDLE.
- A button low at rising edge N is detected from edge N+1. Score, combo and accuracy update at edge N+2.
- A start pulse at edge N gives busy = 1, with the map loaded, after edge N.
- Miss and shift take effect at the edge sampling tick = 1.
- lane_view reflects the map registers combinationally (registered source, no extra latency).
- The DONE transition occurs one edge after the last map bit clears.
- Reset mid-play: everything returns to IDLE/zero on the next edge.
- tick and start asserted together in IDLE: start wins; the loaded map is not shifted that cycle.

## Configuration
- JUDGE_STATS_EN defined:
  - perfect_cnt, good_cnt and miss_cnt count grade events, saturating at 0xFFFF.
  - Counters clear on reset and on start-load.
  - Simultaneous events on several lanes add their count.
- JUDGE_STATS_EN undefined: the three ports remain present but are tied to 0, and no counter logic is built.

## Test plan
- LANES=2, DEPTH=16, lane0 map = 0x0002. Press lane0 before any tick → score 2, combo 1, accuracy[1:0] = 01. A following tick causes no miss.
- Lane0 map = 0x0001, tick with no press → accuracy[1:0] = 11, combo 0, score unchanged. With JUDGE_STATS_EN: miss_cnt 1.
- Both lanes map = 0x0002, both buttons pressed in the same cycle as a tick → score 4, combo 2. Both lanes report perfect, and no miss on the subsequent tick.
- SCORE_W=4, eight perfect hits → score saturates at 15, combo 8, max_combo 8. A miss then gives combo 0 and max_combo 8.
- Stray press on an empty window → accuracy 00, combo unchanged. Start during PLAY → IDLE, busy 0.
- Play until all maps clear → done 1. Then assert rst low mid-run on a second start → all outputs 0 and state IDLE next edge.
